simon_led_player: RTL and testbench

- Output-side counterpart to the key input synchroniser.
- Accepts one colour command at a time over a valid/ready handshake.
- Lights the matching LED for a fixed on-time, then holds all LEDs dark for a fixed gap, then signals completion.
- The game controller drives it to play back the Simon sequence.

---
 rtl/simon_led_player.sv | 155 +++++++++++++++
 tb/tb_simon_led_player.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/simon_led_player.sv
// Simon LED player: flashes one colour LED for ON_CYCLES, stays dark for GAP_CYCLES, then pulses done.
// Optional tone output on the speaker port is enabled with `define SIMON_TONE_EN.
module simon_led_player #(
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 12500000,
    parameter int CNT_W      = 26
`ifdef SIMON_TONE_EN
    ,
    parameter int TONE_HALF0 = 113636,
    parameter int TONE_HALF1 = 95602,
    parameter int TONE_HALF2 = 75843,
    parameter int TONE_HALF3 = 63776
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [1:0] color,
    input  logic       cancel,
    output logic       ready,
    output logic [3:0] led,
    output logic       busy,
    output logic       done
`ifdef SIMON_TONE_EN
    ,
    output logic       speaker
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_GAP
    } state_t;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       color_q;
    logic             done_q, done_next;
    logic             accept;

    assign accept = (state == ST_IDLE) && valid && !cancel;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ON;
                    cnt_next   = ON_LOAD;
                end
            end
            ST_ON: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    if (GAP_CYCLES == 0) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_GAP;
                        cnt_next   = GAP_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            color_q <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            done_q <= done_next;
            if (accept) begin
                color_q <= color;
            end
        end
    end

    // Outputs decode registered state only, so ready never follows valid combinationally.
    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_ON) || (state == ST_GAP);
    assign led   = (state == ST_ON) ? (4'b0001 << color_q) : 4'b0000;
    assign done  = done_q;

`ifdef SIMON_TONE_EN
    localparam int TONE_MAX01 = (TONE_HALF0 > TONE_HALF1) ? TONE_HALF0 : TONE_HALF1;
    localparam int TONE_MAX23 = (TONE_HALF2 > TONE_HALF3) ? TONE_HALF2 : TONE_HALF3;
    localparam int TONE_MAX   = (TONE_MAX01 > TONE_MAX23) ? TONE_MAX01 : TONE_MAX23;
    localparam int TONE_W     = $clog2(TONE_MAX + 1);

    logic [TONE_W-1:0] tone_cnt;
    logic              speaker_q;

    function automatic logic [TONE_W-1:0] tone_load(input logic [1:0] c);
        case (c)
            2'd0:    return TONE_W'(TONE_HALF0 - 1);
            2'd1:    return TONE_W'(TONE_HALF1 - 1);
            2'd2:    return TONE_W'(TONE_HALF2 - 1);
            default: return TONE_W'(TONE_HALF3 - 1);
        endcase
    endfunction

    // Outside a continuing ON phase the tone is held silent and preloaded for the incoming colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            speaker_q <= 1'b0;
            tone_cnt  <= '0;
        end else if (state == ST_ON && state_next == ST_ON) begin
            if (tone_cnt == '0) begin
                speaker_q <= ~speaker_q;
                tone_cnt  <= tone_load(color_q);
            end else begin
                tone_cnt <= tone_cnt - TONE_W'(1);
            end
        end else begin
            speaker_q <= 1'b0;
            tone_cnt  <= tone_load(color);
        end
    end

    assign speaker = speaker_q;
`endif

endmodule

// File: tb/tb_simon_led_player.sv
// Randomized bench for simon_led_player: two instances (GAP=2 and GAP=0) compared each cycle
// against an elapsed-time model of the flash timeline.
module tb_simon_led_player;

    localparam int ON = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic       cancel = 1'b0;
    logic [1:0] color = 2'd0;

    logic       ready_a, busy_a, done_a, spk_a;
    logic [3:0] led_a;
    logic       ready_b, busy_b, done_b, spk_b;
    logic [3:0] led_b;

    always #5 clk = ~clk;

`ifdef SIMON_TONE_EN
    simon_led_player #(
        .ON_CYCLES(ON), .GAP_CYCLES(2), .CNT_W(3),
        .TONE_HALF0(2), .TONE_HALF1(1), .TONE_HALF2(3), .TONE_HALF3(4)
    ) dut_a (
        .clk(clk), .reset(reset), .valid(valid), .color(color), .cancel(cancel),
        .ready(ready_a), .led(led_a), .busy(busy_a), .done(done_a), .speaker(spk_a)
    );
    simon_led_player #(
        .ON_CYCLES(ON), .GAP_CYCLES(0), .CNT_W(3),
        .TONE_HALF0(2), .TONE_HALF1(1), .TONE_HALF2(3), .TONE_HALF3(4)
    ) dut_b (
        .clk(clk), .reset(reset), .valid(valid), .color(color), .cancel(cancel),
        .ready(ready_b), .led(led_b), .busy(busy_b), .done(done_b), .speaker(spk_b)
    );
`else
    simon_led_player #(.ON_CYCLES(ON), .GAP_CYCLES(2), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .valid(valid), .color(color), .cancel(cancel),
        .ready(ready_a), .led(led_a), .busy(busy_a), .done(done_a)
    );
    simon_led_player #(.ON_CYCLES(ON), .GAP_CYCLES(0), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .valid(valid), .color(color), .cancel(cancel),
        .ready(ready_b), .led(led_b), .busy(busy_b), .done(done_b)
    );
    assign spk_a = 1'b0;
    assign spk_b = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h want %0h", tag, edge_n, got, want);
        end
    endtask

    // Model: a flash is described only by its accept edge and colour; outputs follow from elapsed edges.
    int         gap_m [2] = '{2, 0};
    int         half_m[4] = '{2, 1, 3, 4};
    bit         act_m [2] = '{0, 0};
    bit         done_m[2] = '{0, 0};
    int         acc_m [2] = '{0, 0};
    logic [1:0] col_m [2] = '{2'd0, 2'd0};
    int         edge_n = 0;

    task automatic model_edge(input int i);
        done_m[i] = 1'b0;
        if (reset) begin
            act_m[i] = 1'b0;
        end else if (act_m[i]) begin
            if (cancel) begin
                act_m[i] = 1'b0;
            end else if (edge_n - acc_m[i] == ON + gap_m[i]) begin
                act_m[i]  = 1'b0;
                done_m[i] = 1'b1;
            end
        end else if (valid && !cancel) begin
            act_m[i] = 1'b1;
            acc_m[i] = edge_n;
            col_m[i] = color;
        end
    endtask

    function automatic logic [3:0] exp_led(input int i);
        logic [3:0] one = 4'b0001;
        if (act_m[i] && (edge_n - acc_m[i]) < ON) return one << col_m[i];
        return 4'b0000;
    endfunction

    function automatic logic exp_spk(input int i);
`ifdef SIMON_TONE_EN
        int d = edge_n - acc_m[i];
        if (act_m[i] && d < ON) return logic'((d / half_m[col_m[i]]) % 2);
`endif
        return 1'b0;
    endfunction

    task automatic check_all();
        check("a.led",   {4'h0, led_a},   {4'h0, exp_led(0)});
        check("a.busy",  {7'h0, busy_a},  {7'h0, act_m[0]});
        check("a.ready", {7'h0, ready_a}, {7'h0, !act_m[0]});
        check("a.done",  {7'h0, done_a},  {7'h0, done_m[0]});
        check("a.spk",   {7'h0, spk_a},   {7'h0, exp_spk(0)});
        check("b.led",   {4'h0, led_b},   {4'h0, exp_led(1)});
        check("b.busy",  {7'h0, busy_b},  {7'h0, act_m[1]});
        check("b.ready", {7'h0, ready_b}, {7'h0, !act_m[1]});
        check("b.done",  {7'h0, done_b},  {7'h0, done_m[1]});
        check("b.spk",   {7'h0, spk_b},   {7'h0, exp_spk(1)});
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] c, input logic x);
        reset  = r;
        valid  = v;
        color  = c;
        cancel = x;
        @(posedge clk);
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    initial begin
        // Reset for three cycles, then release into IDLE.
        repeat (3) step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);

        // Single flash of colour 2.
        step(1'b0, 1'b1, 2'd2, 1'b0);
        repeat (9) step(1'b0, 1'b0, 2'd0, 1'b0);

        // valid held: colour 0 then colour 3, second accepted on the done cycle.
        step(1'b0, 1'b1, 2'd0, 1'b0);
        repeat (13) step(1'b0, 1'b1, 2'd3, 1'b0);
        repeat (8) step(1'b0, 1'b0, 2'd0, 1'b0);

        // Cancel during the second ON cycle, then valid+cancel together in IDLE.
        step(1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b0, 1'b0, 2'd1, 1'b0);
        step(1'b0, 1'b0, 2'd1, 1'b1);
        repeat (8) step(1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 1'b1);
        repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0);

        // Colour 1 flash (exercises GAP=0 instance), then reset mid-ON.
        step(1'b0, 1'b1, 2'd1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd2, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 2'd0, 1'b0);

        // Random traffic with occasional cancel and reset.
        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 63) == 0),
                 logic'($urandom_range(0, 2) != 0),
                 2'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
